seg_scan_display: RTL and testbench

Parametrised, time-multiplexed seven-segment display driver for the clock design. Takes packed BCD digits from the time/alarm datapath, holds them in a tear-free shadow register, and scans them onto one shared active-low segment bus with active-low digit enables. Adds per-digit blinking for the set-time/set-alarm modes, per-digit decimal points and a seconds-activity LED.

---
 rtl/seg_pkg.sv | 17 +
 rtl/seg_scan_display_if.sv | 22 ++
 rtl/seg_tick_div.sv | 22 ++
 rtl/seg_scan_display.sv | 98 +++++++++
 tb/tb_seg_scan_display.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared seven-segment constants and BCD decode for the clock display path.
package seg_pkg;

  localparam logic [7:0] SEG_BLANK  = 8'hFF;
  localparam int         SEG_DP_BIT = 7;

  // Active-low g..a with dp off; entries 10..15 are blank.
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
    8'h90, 8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  function automatic logic [7:0] seg_decode(input logic [3:0] bcd);
    return SEG_TABLE[bcd];
  endfunction

endpackage

// File: rtl/seg_scan_display_if.sv
// Datapath-to-display bundle: BCD/masks in, scanned segment/digit/LED out.
interface seg_scan_display_if #(
  parameter int NUM_DIGITS = 6
);
  logic [4*NUM_DIGITS-1:0] bcd_in;
  logic                    load;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic [7:0]              seg_n;
  logic [NUM_DIGITS-1:0]   dig_sel_n;
  logic                    sec_led;

  modport master (
    output bcd_in, load, blink_mask, dp_mask,
    input  seg_n, dig_sel_n, sec_led
  );

  modport slave (
    input  bcd_in, load, blink_mask, dp_mask,
    output seg_n, dig_sel_n, sec_led
  );
endinterface

// File: rtl/seg_tick_div.sv
// Free-running modulo-N counter with a terminal-count flag.
module seg_tick_div #(
  parameter  int N = 4,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);
  logic [W-1:0] cnt_q, cnt_d;

  assign tc_o  = (cnt_q == W'(N-1));
  assign cnt_o = cnt_q;

  always_comb cnt_d = tc_o ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;

endmodule

// File: rtl/seg_scan_display.sv
// Time-multiplexed 7-seg driver with shadow register, blink, dp and seconds LED.
// Optional leading-zero suppression: define SEG_LZ_BLANK_EN.
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int SCAN_DIV   = 50000,
  parameter int BLANK_CYC  = 2,
  parameter int BLINK_DIV  = 12500000
) (
  input logic               clk,
  input logic               rst_n,
  seg_scan_display_if.slave bus
);
  localparam int SW = (SCAN_DIV > 1)   ? $clog2(SCAN_DIV)   : 1;
  localparam int BW = (BLINK_DIV > 1)  ? $clog2(BLINK_DIV)  : 1;
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [SW-1:0] scnt;
  logic          scan_tc;
  logic [BW-1:0] unused_bcnt;
  logic          blink_tc;

  logic [DW-1:0]                 didx_q, didx_d;
  logic                          blink_ph_q, blink_ph_d;
  logic [NUM_DIGITS-1:0][3:0]    shadow_q, shadow_d;
  logic                          sec_led_q, sec_led_d;
  logic [7:0]                    seg_q, seg_d;
  logic [NUM_DIGITS-1:0]         dig_q, dig_d;
  logic [NUM_DIGITS-1:0]         lz;

  seg_tick_div #(.N(SCAN_DIV)) u_scan_div (
    .clk(clk), .rst_n(rst_n), .cnt_o(scnt), .tc_o(scan_tc)
  );

  seg_tick_div #(.N(BLINK_DIV)) u_blink_div (
    .clk(clk), .rst_n(rst_n), .cnt_o(unused_bcnt), .tc_o(blink_tc)
  );

  always_comb begin
    shadow_d   = bus.load ? bus.bcd_in : shadow_q;
    sec_led_d  = (bus.load && (bus.bcd_in[3:0] != shadow_q[0])) ? ~sec_led_q : sec_led_q;
    blink_ph_d = blink_tc ? ~blink_ph_q : blink_ph_q;
    didx_d     = didx_q;
    if (scan_tc) didx_d = (didx_q == DW'(NUM_DIGITS-1)) ? '0 : didx_q + 1'b1;
  end

  // Digit i is a leading zero when it and every digit above it are zero.
  always_comb begin
    lz = '0;
`ifdef SEG_LZ_BLANK_EN
    begin
      logic zrun;
      zrun = 1'b1;
      for (int i = NUM_DIGITS-1; i > 0; i--) begin
        zrun  = zrun & (shadow_q[i] == 4'd0);
        lz[i] = zrun;
      end
    end
`endif
  end

  // Outputs are built from the registered shadow, so a load never tears a slot.
  always_comb begin
    seg_d = seg_decode(shadow_q[didx_q]);
    if (lz[didx_q]) seg_d = SEG_BLANK;
    seg_d[SEG_DP_BIT] = ~bus.dp_mask[didx_q];
    if (blink_ph_q && bus.blink_mask[didx_q]) seg_d = SEG_BLANK;
    dig_d = ~(NUM_DIGITS'(1) << didx_q);
    if (scnt < SW'(BLANK_CYC)) begin
      seg_d = SEG_BLANK;
      dig_d = '1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      didx_q     <= '0;
      blink_ph_q <= 1'b0;
      shadow_q   <= '0;
      sec_led_q  <= 1'b1;
      seg_q      <= SEG_BLANK;
      dig_q      <= '1;
    end else begin
      didx_q     <= didx_d;
      blink_ph_q <= blink_ph_d;
      shadow_q   <= shadow_d;
      sec_led_q  <= sec_led_d;
      seg_q      <= seg_d;
      dig_q      <= dig_d;
    end
  end

  assign bus.seg_n     = seg_q;
  assign bus.dig_sel_n = dig_q;
  assign bus.sec_led   = sec_led_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display (4 digits, 4-cycle slots, 1 blank cycle, 32-cycle blink).
module tb_seg_scan_display;
  localparam int ND = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n = 0;
  int   checks = 0;
  int   errs = 0;
  logic [ND-1:0] bm_tb = '0;

  seg_scan_display_if #(.NUM_DIGITS(ND)) bus ();

  seg_scan_display #(
    .NUM_DIGITS(ND), .SCAN_DIV(4), .BLANK_CYC(1), .BLINK_DIV(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, n);
    end
  endtask

  // n counts edges since reset release; sampling is 1 time unit after the edge.
  task automatic step();
    @(posedge clk); #1;
    n++;
  endtask

  task automatic load_val(input logic [15:0] v);
    bus.bcd_in = v;
    bus.load   = 1'b1;
    step();
    bus.load   = 1'b0;
  endtask

  // Output at sample n reflects slot cycle (n-1)%4, digit ((n-1)/4)%4, blink phase ((n-1)/32)%2.
  task automatic scan_check(input string tag, input logic [3:0][7:0] tab, input int ncyc);
    int s, d, ph;
    logic [7:0] es;
    logic [3:0] ed;
    for (int k = 0; k < ncyc; k++) begin
      step();
      s  = (n-1) % 4;
      d  = ((n-1) / 4) % 4;
      ph = ((n-1) / 32) % 2;
      if (s < 1) begin
        es = 8'hFF;
        ed = 4'hF;
      end else begin
        es = (ph == 1 && bm_tb[d]) ? 8'hFF : tab[d];
        ed = ~(4'b0001 << d);
      end
      chk(tag, {20'h0, bus.dig_sel_n, bus.seg_n}, {20'h0, ed, es});
    end
  endtask

  initial begin
    bus.bcd_in     = '0;
    bus.load       = 1'b0;
    bus.blink_mask = '0;
    bus.dp_mask    = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_seg", bus.seg_n, 8'hFF);
    chk("rst_dig", bus.dig_sel_n, 4'hF);
    chk("rst_led", bus.sec_led, 1'b1);
    rst_n = 1'b1;
    n = 0;

    step();
    chk("rel_blank", {bus.dig_sel_n, bus.seg_n}, {4'hF, 8'hFF});
    step();
    chk("rel_dig0", {bus.dig_sel_n, bus.seg_n}, {4'hE, 8'hC0});

    load_val(16'h1234);
    chk("led_1234", bus.sec_led, 1'b0);
    scan_check("scan_1234", {8'hF9, 8'hA4, 8'hB0, 8'h99}, 16);

    bus.blink_mask = 4'b1100;
    bm_tb          = 4'b1100;
    scan_check("blink", {8'hF9, 8'hA4, 8'hB0, 8'h99}, 64);
    bus.blink_mask = '0;
    bm_tb          = '0;

    load_val(16'h0001);
    chk("led_0001a", bus.sec_led, 1'b1);
    load_val(16'h0001);
    chk("led_0001b", bus.sec_led, 1'b1);
    load_val(16'h0002);
    chk("led_0002", bus.sec_led, 1'b0);
    bus.bcd_in = 16'h0009;
    repeat (8) step();
    chk("led_noload", bus.sec_led, 1'b0);
`ifdef SEG_LZ_BLANK_EN
    scan_check("noload", {8'hFF, 8'hFF, 8'hFF, 8'hA4}, 16);
`else
    scan_check("noload", {8'hC0, 8'hC0, 8'hC0, 8'hA4}, 16);
`endif

    bus.dp_mask = 4'b0100;
    load_val(16'h05A3);
    chk("led_05a3", bus.sec_led, 1'b1);
`ifdef SEG_LZ_BLANK_EN
    scan_check("inv_dp", {8'hFF, 8'h12, 8'hFF, 8'hB0}, 16);
`else
    scan_check("inv_dp", {8'hC0, 8'h12, 8'hFF, 8'hB0}, 16);
`endif
    bus.dp_mask = '0;

    load_val(16'h0005);
    chk("led_0005", bus.sec_led, 1'b0);
`ifdef SEG_LZ_BLANK_EN
    scan_check("lz_0005", {8'hFF, 8'hFF, 8'hFF, 8'h92}, 16);
`else
    scan_check("lz_0005", {8'hC0, 8'hC0, 8'hC0, 8'h92}, 16);
`endif
    load_val(16'h0000);
    chk("led_0000", bus.sec_led, 1'b1);
`ifdef SEG_LZ_BLANK_EN
    scan_check("lz_0000", {8'hFF, 8'hFF, 8'hFF, 8'hC0}, 16);
`else
    scan_check("lz_0000", {8'hC0, 8'hC0, 8'hC0, 8'hC0}, 16);
`endif

    // Mid-frame async reset on a lit cycle of a non-zero digit.
    load_val(16'h1234);
    while (!(((n-1) % 4) == 2 && ((n-1) / 4) % 4 == 2)) step();
    chk("pre_rst_dig", bus.dig_sel_n, 4'hB);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_seg", bus.seg_n, 8'hFF);
    chk("mid_rst_dig", bus.dig_sel_n, 4'hF);
    chk("mid_rst_led", bus.sec_led, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n = 0;
    step();
    chk("rst2_blank", {bus.dig_sel_n, bus.seg_n}, {4'hF, 8'hFF});
    step();
    chk("rst2_dig0", {bus.dig_sel_n, bus.seg_n}, {4'hE, 8'hC0});

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

endmodule
